// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
//   Groups the MEM/WB handshake and payload signals.
//   master : the MEM-side producer and WB-side consumer (drives in_*, out_ready)
//   slave  : the mem_wb_stage itself (drives in_ready, out_*, occupancy)
//   Signals:
//     in_valid/in_ready     input handshake
//     in_mem_rd, in_wb_en   load flag, register-file write enable
//     in_dest, in_alu,
//     in_mem_data           input payload
//     out_valid/out_ready   output handshake
//     out_mem_rd, out_wb_en head load flag, gated write strobe
//     out_dest, out_wb_data head destination and selected writeback data
//     out_packed            legacy {mem_rd, wb_en, dest, alu, mem_data} word
//     occupancy             held entries, 0..2
interface mem_wb_stage_if #(
    parameter int DATA_W = 16,
    parameter int MEM_W  = 12,
    parameter int REG_AW = 4
);
    localparam int PACK_W = 2 + REG_AW + DATA_W + MEM_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_mem_rd;
    logic              in_wb_en;
    logic [REG_AW-1:0] in_dest;
    logic [DATA_W-1:0] in_alu;
    logic [MEM_W-1:0]  in_mem_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_mem_rd;
    logic              out_wb_en;
    logic [REG_AW-1:0] out_dest;
    logic [DATA_W-1:0] out_wb_data;
    logic [PACK_W-1:0] out_packed;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_mem_rd, in_wb_en, in_dest, in_alu, in_mem_data, out_ready,
        input  in_ready, out_valid, out_mem_rd, out_wb_en, out_dest, out_wb_data,
               out_packed, occupancy
    );

    modport slave (
        input  in_valid, in_mem_rd, in_wb_en, in_dest, in_alu, in_mem_data, out_ready,
        output in_ready, out_valid, out_mem_rd, out_wb_en, out_dest, out_wb_data,
               out_packed, occupancy
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   Parametrised MEM/WB pipeline register with a valid/ready handshake and a
//   2-entry skid buffer (HEAD + SKID) so the WB stage can stall without a
//   combinational ready path. Adds flush, writeback-data select, occupancy
//   reporting and keeps the legacy packed output word.
//   Ports:
//     clock    rising-edge clock
//     reset_n  asynchronous active-low reset, clears entries and payload
//     flush    drops held entries and the current input beat
//     bus      mem_wb_stage_if.slave, handshake and payload signals
module mem_wb_stage #(
    parameter int DATA_W = 16,
    parameter int MEM_W  = 12,
    parameter int REG_AW = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    mem_wb_stage_if.slave        bus
);
    localparam int PACK_W = 2 + REG_AW + DATA_W + MEM_W;

    function automatic logic [DATA_W-1:0] wb_sel(
        input logic              mem_rd,
        input logic [DATA_W-1:0] alu,
        input logic [MEM_W-1:0]  mem_data
    );
        if (mem_rd) return DATA_W'(mem_data);
        return alu;
    endfunction

    // SKID entry (_p0) and HEAD entry (_p1)
    logic              vld_p0, vld_p1;
    logic              mem_rd_p0, mem_rd_p1;
    logic              wb_en_p0, wb_en_p1;
    logic [REG_AW-1:0] dest_p0, dest_p1;
    logic [DATA_W-1:0] alu_p0, alu_p1;
    logic [MEM_W-1:0]  mem_data_p0, mem_data_p1;

    logic pop, accept, head_free;

    assign bus.in_ready = !vld_p0;
    assign pop          = vld_p1 & bus.out_ready;
    assign accept       = bus.in_valid & !vld_p0 & !flush;
    assign head_free    = !vld_p1 | pop;

    // input -> SKID / HEAD
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            mem_rd_p0   <= 1'b0;
            wb_en_p0    <= 1'b0;
            dest_p0     <= '0;
            alu_p0      <= '0;
            mem_data_p0 <= '0;
            mem_rd_p1   <= 1'b0;
            wb_en_p1    <= 1'b0;
            dest_p1     <= '0;
            alu_p1      <= '0;
            mem_data_p1 <= '0;
        end else if (flush) begin
            // payloads keep their values so the idle outputs do not toggle
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else if (head_free) begin
            if (vld_p0) begin
                // in_ready was low, so no input can be accepted this edge
                vld_p1      <= 1'b1;
                vld_p0      <= 1'b0;
                mem_rd_p1   <= mem_rd_p0;
                wb_en_p1    <= wb_en_p0;
                dest_p1     <= dest_p0;
                alu_p1      <= alu_p0;
                mem_data_p1 <= mem_data_p0;
            end else if (accept) begin
                vld_p1      <= 1'b1;
                mem_rd_p1   <= bus.in_mem_rd;
                wb_en_p1    <= bus.in_wb_en;
                dest_p1     <= bus.in_dest;
                alu_p1      <= bus.in_alu;
                mem_data_p1 <= bus.in_mem_data;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (accept) begin
            vld_p0      <= 1'b1;
            mem_rd_p0   <= bus.in_mem_rd;
            wb_en_p0    <= bus.in_wb_en;
            dest_p0     <= bus.in_dest;
            alu_p0      <= bus.in_alu;
            mem_data_p0 <= bus.in_mem_data;
        end
    end

    // HEAD -> WB
    assign bus.out_valid   = vld_p1;
    assign bus.out_mem_rd  = mem_rd_p1;
    assign bus.out_wb_en   = vld_p1 & wb_en_p1;
    assign bus.out_dest    = dest_p1;
    assign bus.out_wb_data = wb_sel(mem_rd_p1, alu_p1, mem_data_p1);
    assign bus.out_packed  = PACK_W'({mem_rd_p1, wb_en_p1, dest_p1, alu_p1, mem_data_p1});
    assign bus.occupancy   = {1'b0, vld_p1} + {1'b0, vld_p0};
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    localparam int DATA_W = 16;
    localparam int MEM_W  = 12;
    localparam int REG_AW = 4;
    localparam int PACK_W = 2 + REG_AW + DATA_W + MEM_W;

    typedef struct {
        logic [PACK_W-1:0] pk;
        logic [DATA_W-1:0] wb;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    mem_wb_stage_if #(.DATA_W(DATA_W), .MEM_W(MEM_W), .REG_AW(REG_AW)) bus ();

    mem_wb_stage #(.DATA_W(DATA_W), .MEM_W(MEM_W), .REG_AW(REG_AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mem_rd, input logic wb, input logic [REG_AW-1:0] dest,
                         input logic [DATA_W-1:0] alu, input logic [MEM_W-1:0] md);
        bus.in_valid    = 1'b1;
        bus.in_mem_rd   = mem_rd;
        bus.in_wb_en    = wb;
        bus.in_dest     = dest;
        bus.in_alu      = alu;
        bus.in_mem_data = md;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // scoreboard: queue length mirrors held entries
    always @(negedge clock) begin
        int n;
        exp_t e;
        if (!reset_n) begin
            sb.delete();
        end else begin
            n = sb.size();
            chk("occupancy", 64'(bus.occupancy), 64'(n));
            chk("in_ready", 64'(bus.in_ready), 64'(n < 2));
            chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
            if (n > 0) begin
                chk("sb_packed", 64'(bus.out_packed), 64'(sb[0].pk));
                chk("sb_wb_data", 64'(bus.out_wb_data), 64'(sb[0].wb));
                chk("sb_wb_en", 64'(bus.out_wb_en), 64'(sb[0].pk[PACK_W-2]));
                if (bus.out_ready) void'(sb.pop_front());
            end else begin
                chk("idle_wb_en", 64'(bus.out_wb_en), 64'(0));
            end
            if (flush) begin
                sb.delete();
            end else if (bus.in_valid && n < 2) begin
                e.pk = {bus.in_mem_rd, bus.in_wb_en, bus.in_dest, bus.in_alu, bus.in_mem_data};
                e.wb = bus.in_mem_rd ? {{(DATA_W-MEM_W){1'b0}}, bus.in_mem_data} : bus.in_alu;
                sb.push_back(e);
            end
        end
    end

    initial begin
        logic [PACK_W-1:0] held;
        bus.in_valid = 1'b0; bus.in_mem_rd = 1'b0; bus.in_wb_en = 1'b0;
        bus.in_dest = '0; bus.in_alu = '0; bus.in_mem_data = '0; bus.out_ready = 1'b1;

        // reset state
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_packed", 64'(bus.out_packed), 64'(0));
        chk("rst_wb_data", 64'(bus.out_wb_data), 64'(0));
        chk("rst_occ", 64'(bus.occupancy), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        reset_n = 1'b1;
        step();

        // streaming, one beat per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, REG_AW'(i), DATA_W'(16'h1000 + i), MEM_W'(i));
            step();
            chk("stream_valid", 64'(bus.out_valid), 64'(1));
            chk("stream_dest", 64'(bus.out_dest), 64'(i));
            chk("stream_wb", 64'(bus.out_wb_data), 64'(16'h1000 + i));
        end
        bus.in_valid = 1'b0;
        step();

        // load select
        drive(1'b1, 1'b1, 4'd5, 16'hBEEF, 12'hABC);
        step();
        bus.in_valid = 1'b0;
        chk("load_wb_data", 64'(bus.out_wb_data), 64'h0ABC);
        chk("load_packed", 64'(bus.out_packed), 64'({1'b1, 1'b1, 4'd5, 16'hBEEF, 12'hABC}));
        step();

        // backpressure
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b1, 4'd10, 16'hA000, 12'h00A);
        step();
        drive(1'b1, 1'b0, 4'd11, 16'hB000, 12'h00B);
        step();
        drive(1'b0, 1'b1, 4'd12, 16'hC000, 12'h00C);
        step();
        chk("bp_occ", 64'(bus.occupancy), 64'(2));
        chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
        held = {1'b0, 1'b1, 4'd10, 16'hA000, 12'h00A};
        chk("bp_hold0", 64'(bus.out_packed), 64'(held));
        step();
        chk("bp_hold1", 64'(bus.out_packed), 64'(held));
        bus.out_ready = 1'b1;
        step();
        chk("bp_second", 64'(bus.out_dest), 64'(11));
        chk("bp_occ1", 64'(bus.occupancy), 64'(1));
        step();
        bus.in_valid = 1'b0;
        chk("bp_third", 64'(bus.out_dest), 64'(12));
        step();
        chk("bp_drain", 64'(bus.occupancy), 64'(0));

        // flush with a full buffer and a pending input beat
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b1, 4'd1, 16'h1111, 12'h111);
        step();
        drive(1'b0, 1'b1, 4'd2, 16'h2222, 12'h222);
        step();
        drive(1'b0, 1'b1, 4'd3, 16'h3333, 12'h333);
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_occ", 64'(bus.occupancy), 64'(0));
        chk("fl_wb_en", 64'(bus.out_wb_en), 64'(0));
        chk("fl_in_ready", 64'(bus.in_ready), 64'(1));
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 4'd4, 16'h4444, 12'h444);
        step();
        bus.in_valid = 1'b0;
        chk("fl_next", 64'(bus.out_dest), 64'(4));
        step();

        // write-strobe gating
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b1, 4'd7, 16'h7777, 12'h777);
        step();
        bus.in_valid = 1'b0;
        chk("wb_gate_on", 64'(bus.out_wb_en), 64'(1));
        step();
        chk("wb_gate_hold", 64'(bus.out_wb_en), 64'(1));
        bus.out_ready = 1'b1;
        step();
        chk("wb_gate_off", 64'(bus.out_wb_en), 64'(0));
        chk("idle_dest_held", 64'(bus.out_dest), 64'(7));
        chk("idle_wb_held", 64'(bus.out_wb_data), 64'(16'h7777));

        // reset asserted mid-transfer
        bus.out_ready = 1'b0;
        drive(1'b0, 1'b1, 4'd8, 16'h8888, 12'h888);
        step();
        drive(1'b0, 1'b1, 4'd9, 16'h9999, 12'h999);
        step();
        bus.in_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_occ", 64'(bus.occupancy), 64'(0));
        chk("mrst_valid", 64'(bus.out_valid), 64'(0));
        chk("mrst_packed", 64'(bus.out_packed), 64'(0));
        chk("mrst_in_ready", 64'(bus.in_ready), 64'(1));
        step();
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("sb_left", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
